// File: rtl/fpnew_pkg.sv
// Shared FPnew types: floating-point formats, status flags and format helpers.
// Only the subset needed by the dot-product result packer is provided here.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP64:          return 32'd64;
      FP16, FP16ALT: return 32'd16;
      FP8:           return 32'd8;
      default:       return 32'd32;
    endcase
  endfunction

  // Slots of a given format that fit a packed word; formats at least as wide
  // as the word occupy a single slot.
  function automatic int unsigned num_pack_slots(fp_format_e fmt, int unsigned width);
    int unsigned w;
    w = fp_width(fmt);
    return (w < width) ? width / w : 32'd1;
  endfunction

endpackage

// File: rtl/fpnew_pack_outreg.sv
// Single-entry valid/ready output register with load and flush.
// The owner only asserts load_i when the entry is empty or draining this cycle.
module fpnew_pack_outreg #(
  parameter type   data_t   = logic,
  parameter data_t ResetVal = data_t'('0)
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  flush_i,
  input  logic  load_i,
  input  data_t data_i,
  input  logic  ready_i,
  output logic  valid_o,
  output data_t data_o
);

  logic  valid_q;
  data_t data_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= ResetVal;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fpnew_dotp_result_packer.sv
// Packs scalar dot-product results LSB-first into a SIMD word, NaN-boxing
// unfilled slots and OR-ing status flags, behind a registered output stage.
module fpnew_dotp_result_packer import fpnew_pkg::*; #(
  parameter  int unsigned PackWidth = 64,
  parameter  int unsigned ResWidth  = 32,
  parameter  type         TagType   = logic,
  localparam int unsigned NumWidth  = $clog2(PackWidth/8) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ResWidth-1:0]  result_i,
  input  fp_format_e           dst_fmt_i,
  input  status_t              status_i,
  input  TagType               tag_i,
  input  logic                 last_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 flush_i,
  output logic [PackWidth-1:0] packed_o,
  output status_t              status_o,
  output TagType               tag_o,
  output logic [NumWidth-1:0]  num_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 busy_o
);

  typedef struct packed {
    logic [PackWidth-1:0] word;
    status_t              status;
    TagType               tag;
    logic [NumWidth-1:0]  num;
  } out_t;

  localparam out_t OutReset = '{word: '1, default: '0};

  logic [PackWidth-1:0] buf_q, buf_d, ins_buf, slot_mask, res_ext;
  logic [NumWidth-1:0]  cnt_q, cnt_d, cnt_inc;
  fp_format_e           fmt_q, fmt_d;
  status_t              status_q, status_d;
  TagType               tag_q, tag_d;
  int unsigned          fmt_w, slots, slot_off;
  logic                 out_valid, out_free, fmt_conflict, accept, close, force_close;
  out_t                 load_data, out_data;

  if (ResWidth >= PackWidth) begin : g_res_trunc
    assign res_ext = result_i[PackWidth-1:0];
  end else begin : g_res_zext
    assign res_ext = {{(PackWidth-ResWidth){1'b0}}, result_i};
  end

  assign cnt_inc      = cnt_q + NumWidth'(1);
  assign fmt_conflict = (cnt_q != '0) && (dst_fmt_i != fmt_q) && in_valid_i;
  assign out_free     = !out_valid || out_ready_i;
  assign in_ready_o   = out_free && !fmt_conflict && !flush_i;
  assign accept       = in_valid_i && in_ready_o;
  // A conflicting format closes the current partial pack to make room.
  assign force_close  = fmt_conflict && out_free && !flush_i;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through this block can infer a latch.
    fmt_w     = fp_width(dst_fmt_i);
    slots     = num_pack_slots(dst_fmt_i, PackWidth);
    slot_off  = 32'(cnt_q) * fmt_w;
    slot_mask = '0;
    for (int unsigned i = 0; i < PackWidth; i++) begin
      if (i < fmt_w) slot_mask[i] = 1'b1;
    end
    ins_buf = (buf_q & ~(slot_mask << slot_off)) | ((res_ext & slot_mask) << slot_off);
    close   = accept && ((32'(cnt_inc) == slots) || last_i);

    load_data = '{word: buf_q, status: status_q, tag: tag_q, num: cnt_q};
    if (close) begin
      load_data = '{word: ins_buf, status: status_q | status_i, tag: tag_i, num: cnt_inc};
    end

    buf_d    = buf_q;
    cnt_d    = cnt_q;
    fmt_d    = fmt_q;
    status_d = status_q;
    tag_d    = tag_q;
    if (flush_i || close || force_close) begin
      buf_d    = '1;
      cnt_d    = '0;
      status_d = '0;
    end else if (accept) begin
      buf_d    = ins_buf;
      cnt_d    = cnt_inc;
      fmt_d    = dst_fmt_i;
      status_d = status_q | status_i;
      tag_d    = tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q    <= '1;
      cnt_q    <= '0;
      fmt_q    <= FP32;
      status_q <= '0;
      tag_q    <= '0;
    end else begin
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      fmt_q    <= fmt_d;
      status_q <= status_d;
      tag_q    <= tag_d;
    end
  end

  fpnew_pack_outreg #(
    .data_t   (out_t),
    .ResetVal (OutReset)
  ) i_outreg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .load_i  (close || force_close),
    .data_i  (load_data),
    .ready_i (out_ready_i),
    .valid_o (out_valid),
    .data_o  (out_data)
  );

  assign out_valid_o = out_valid;
  assign packed_o    = out_data.word;
  assign status_o    = out_data.status;
  assign tag_o       = out_data.tag;
  assign num_o       = out_data.num;
  assign busy_o      = (cnt_q != '0) || out_valid;

endmodule

// File: tb/tb_fpnew_dotp_result_packer.sv
// Table-driven bench for the dot-product result packer: each row drives one
// cycle of inputs and lists the expected handshake and packed outputs.
module tb_fpnew_dotp_result_packer;
  import fpnew_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] result_i;
  fp_format_e  dst_fmt_i;
  status_t     status_i;
  logic        tag_i, last_i, in_valid_i, in_ready_o, flush_i;
  logic [63:0] packed_o;
  status_t     status_o;
  logic        tag_o;
  logic [3:0]  num_o;
  logic        out_valid_o, out_ready_i, busy_o;

  always #5 clk = ~clk;

  fpnew_dotp_result_packer #(
    .PackWidth (64),
    .ResWidth  (32),
    .TagType   (logic)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .result_i    (result_i),
    .dst_fmt_i   (dst_fmt_i),
    .status_i    (status_i),
    .tag_i       (tag_i),
    .last_i      (last_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .flush_i     (flush_i),
    .packed_o    (packed_o),
    .status_o    (status_o),
    .tag_o       (tag_o),
    .num_o       (num_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic        rst, valid, last, flush, ordy;
    fp_format_e  fmt;
    logic [31:0] res;
    logic [4:0]  st;
    logic        tag;
    logic        e_rdy, e_val, e_busy, chk;
    logic [63:0] e_pk;
    logic [3:0]  e_num;
    logic [4:0]  e_st;
    logic        e_tag;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;
  int   row    = -1;
  localparam logic [63:0] ONES = '1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic valid, input fp_format_e fmt,
                     input logic [31:0] res, input logic [4:0] st, input logic tag,
                     input logic last, input logic flush, input logic ordy,
                     input logic e_rdy, input logic e_val, input logic e_busy,
                     input logic chk, input logic [63:0] e_pk, input logic [3:0] e_num,
                     input logic [4:0] e_st, input logic e_tag);
    vec_t v;
    v.rst = rst; v.valid = valid; v.fmt = fmt; v.res = res; v.st = st; v.tag = tag;
    v.last = last; v.flush = flush; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_busy = e_busy; v.chk = chk;
    v.e_pk = e_pk; v.e_num = e_num; v.e_st = e_st; v.e_tag = e_tag;
    vq.push_back(v);
  endtask

  task automatic idle_row(input logic e_busy);
    add(0, 0, FP32, 0, 0, 0, 0, 0, 1,  1, 0, e_busy,  0, 0, 0, 0, 0);
  endtask

  task automatic apply(input vec_t v);
    rst_i       = v.rst;
    in_valid_i  = v.valid;
    dst_fmt_i   = v.fmt;
    result_i    = v.res;
    status_i    = status_t'(v.st);
    tag_i       = v.tag;
    last_i      = v.last;
    flush_i     = v.flush;
    out_ready_i = v.ordy;
    #1;
    check("in_ready", 64'(in_ready_o), 64'(v.e_rdy));
    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid_o), 64'(v.e_val));
    check("busy", 64'(busy_o), 64'(v.e_busy));
    if (v.chk) begin
      check("packed", packed_o, v.e_pk);
      check("num", 64'(num_o), 64'(v.e_num));
      check("status", 64'(status_o), 64'(v.e_st));
      check("tag", 64'(tag_o), 64'(v.e_tag));
    end
  endtask

  initial begin
    // FP16 x4 fill, full throughput consumer.
    add(0, 1, FP16, 32'h3C00, 0, 0, 0, 0, 1,  1, 0, 1,  0, 0, 0, 0, 0);
    add(0, 1, FP16, 32'h4000, 0, 0, 0, 0, 1,  1, 0, 1,  0, 0, 0, 0, 0);
    add(0, 1, FP16, 32'h4200, 0, 0, 0, 0, 1,  1, 0, 1,  0, 0, 0, 0, 0);
    add(0, 1, FP16, 32'h4400, 0, 0, 0, 0, 1,  1, 1, 1,  1, 64'h4400_4200_4000_3C00, 4, 0, 0);
    idle_row(0);
    // Single FP32 beat with last: one slot, upper half NaN-boxed.
    add(0, 1, FP32, 32'h3F80_0000, 0, 1, 1, 0, 1,  1, 1, 1,  1, 64'hFFFF_FFFF_3F80_0000, 1, 0, 1);
    idle_row(0);
    // Format conflict: forced close of the FP16 partial, FP32 beat stalls once.
    add(0, 1, FP16, 32'h3C00, 0, 0, 0, 0, 1,  1, 0, 1,  0, 0, 0, 0, 0);
    add(0, 1, FP32, 32'h4000_0000, 0, 1, 1, 0, 1,  0, 1, 1,  1, 64'hFFFF_FFFF_FFFF_3C00, 1, 0, 0);
    add(0, 1, FP32, 32'h4000_0000, 0, 1, 1, 0, 1,  1, 1, 1,  1, 64'hFFFF_FFFF_4000_0000, 1, 0, 1);
    idle_row(0);
    // Flush drops a partial pack; the beat offered during flush is refused.
    add(0, 1, FP16, 32'h1111, 0, 0, 0, 0, 1,  1, 0, 1,  0, 0, 0, 0, 0);
    add(0, 1, FP16, 32'h2222, 0, 0, 0, 0, 1,  1, 0, 1,  0, 0, 0, 0, 0);
    add(0, 1, FP16, 32'h3333, 0, 0, 0, 1, 1,  0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, FP16, 32'hA001, 0, 0, 0, 0, 1,  1, 0, 1,  0, 0, 0, 0, 0);
    add(0, 1, FP16, 32'hA002, 0, 0, 0, 0, 1,  1, 0, 1,  0, 0, 0, 0, 0);
    add(0, 1, FP16, 32'hA003, 0, 0, 0, 0, 1,  1, 0, 1,  0, 0, 0, 0, 0);
    add(0, 1, FP16, 32'hA004, 0, 0, 0, 0, 1,  1, 1, 1,  1, 64'hA004_A003_A002_A001, 4, 0, 0);
    idle_row(0);
    // Eight FP8 beats, NX on beat 3, then 5 cycles of backpressure.
    for (int k = 1; k <= 8; k++) begin
      add(0, 1, FP8, 32'(k), (k == 3) ? 5'b00001 : 5'b00000, 0, 0, 0, 0,
          1, (k == 8), 1,  (k == 8), 64'h0807_0605_0403_0201, 8, 5'b00001, 0);
    end
    for (int k = 0; k < 5; k++) begin
      add(0, 1, FP8, 32'h11, 0, 0, 1, 0, 0,  0, 1, 1,  1, 64'h0807_0605_0403_0201, 8, 5'b00001, 0);
    end
    // Drain and reload in the same cycle, then the next pack waits.
    add(0, 1, FP8, 32'h11, 0, 0, 1, 0, 1,  1, 1, 1,  1, 64'hFFFF_FFFF_FFFF_FF11, 1, 0, 0);
    add(0, 1, FP8, 32'h22, 0, 0, 1, 0, 0,  0, 1, 1,  1, 64'hFFFF_FFFF_FFFF_FF11, 1, 0, 0);
    idle_row(0);
    // Continuous FP32 stream: a packed word every second cycle.
    add(0, 1, FP32, 32'h1000_0001, 0, 0, 0, 0, 1,  1, 0, 1,  0, 0, 0, 0, 0);
    add(0, 1, FP32, 32'h1000_0002, 0, 0, 0, 0, 1,  1, 1, 1,  1, 64'h1000_0002_1000_0001, 2, 0, 0);
    add(0, 1, FP32, 32'h1000_0003, 0, 0, 0, 0, 1,  1, 0, 1,  0, 0, 0, 0, 0);
    add(0, 1, FP32, 32'h1000_0004, 0, 0, 0, 0, 1,  1, 1, 1,  1, 64'h1000_0004_1000_0003, 2, 0, 0);
    add(0, 1, FP32, 32'h1000_0005, 0, 0, 0, 0, 1,  1, 0, 1,  0, 0, 0, 0, 0);
    // Reset mid-pack discards the partial and restores reset outputs.
    add(1, 1, FP32, 32'h1000_0006, 0, 1, 0, 0, 1,  1, 0, 0,  1, ONES, 0, 0, 0);
    add(0, 1, FP32, 32'h1000_0007, 0, 0, 0, 0, 1,  1, 0, 1,  0, 0, 0, 0, 0);
    add(0, 1, FP32, 32'h1000_0008, 0, 0, 0, 0, 1,  1, 1, 1,  1, 64'h1000_0008_1000_0007, 2, 0, 0);
    idle_row(0);

    // Power-on reset, checked by hand before the table runs.
    rst_i = 1'b1; in_valid_i = 1'b0; dst_fmt_i = FP32; result_i = '0;
    status_i = '0; tag_i = 1'b0; last_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_packed", packed_o, ONES);
    check("rst_num", 64'(num_o), 64'd0);
    check("rst_status", 64'(status_o), 64'd0);
    check("rst_tag", 64'(tag_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);

    foreach (vq[i]) begin
      row = i;
      apply(vq[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
